uart_rx_framed: RTL and testbench
=================================

Name: uart_rx_framed

Overview:
Parametrised UART receiver. Configurable data width, parity and stop-bit count, and 3-sample majority voting at each bit centre. Sits between the baud-tick generator (`sample_trigger` source) and byte consumers. Delivers words over a ready/valid handshake with per-word error flags and an overrun indication.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first on the line.
- PARITY, PARITY_NONE: parity mode, one of PARITY_NONE / PARITY_ODD / PARITY_EVEN.
- STOP_BITS, 1: stop bits checked, legal 1 or 2.
- OVERSAMPLE, 16: `sample_trigger` pulses per bit period, even, >= 4.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- sample_trigger  in  1  1-clk pulse at OVERSAMPLE x bitrate.
- raw_data  in  1  asynchronous serial line, idle high.
- data  out  DATA_BITS  received word.
- data_valid  out  1  word available; held until accepted.
- data_ready  in  1  consumer accepts when data_valid && data_ready.
- parity_error  out  1  sideband of data; parity mismatch (0 when PARITY_NONE).
- frame_error  out  1  sideband of data; a stop bit sampled 0.
- break_detected  out  1  sideband of data; all data, parity and stop samples 0.
- overrun  out  1  1-clk pulse: a completed frame was dropped.

Behaviour:
- raw_data passes through a 2-FF synchroniser before any use; 2-clk input latency.
- Tick counter runs 0..OVERSAMPLE-1 and advances only on sample_trigger. Let C = OVERSAMPLE/2.
- Bit decision: majority of the synchronised samples at ticks C-1, C, C+1 of each bit period, resolved at tick C+1.
- Reset: state IDLE, counters 0, data 0, data_valid 0, all flags 0, overrun 0, synchroniser FFs 1.
- State IDLE:
  - On a sample_trigger with synchronised line 0, enter START with tick counter 0.
- State START:
  - Vote resolves 1 (false start/glitch): return to IDLE with no output and no flags.
  - Vote resolves 0: go to DATA.
- State DATA:
  - DATA_BITS votes, shifted LSB first, bit counter 0..DATA_BITS-1.
  - Then go to PARITY if PARITY != PARITY_NONE, else to STOP.
- State PARITY:
  - One vote.
  - Odd mode: error if XOR(data, parity bit) == 0.
  - Even mode: error if XOR(data, parity bit) == 1.
- State STOP:
  - STOP_BITS votes; any 0 sets the frame error.
  - Completion happens at the final stop vote (mid-bit), not at bit end, so back-to-back frames are not missed.
- Completion:
  - If data_valid == 0, or data_valid && data_ready in the same clk: load data and the three flags, and data_valid = 1 on the next clk edge. Latency is 1 clk after the final stop vote.
  - Otherwise (data_valid && !data_ready): keep the old word and flags, discard the new frame, pulse overrun for 1 clk.
- After completion:
  - frame_error clear: go to IDLE.
  - frame_error set: go to WAIT_IDLE.
- State WAIT_IDLE: stay until one sample_trigger sees a synchronised line of 1, then go to IDLE. A held-low break therefore yields exactly one word.
- Handshake:
  - data_valid drops the clk after acceptance unless a new completion loads in the same clk.
  - data and flags are stable while data_valid is high and not accepted.
- Flags are meaningful only while data_valid = 1.
- sample_trigger absent: no state change other than the synchroniser and handshake.
- rst mid-frame: return to the reset state next clk; a partial frame is discarded; a pending word is dropped without overrun.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum: PARITY_NONE, PARITY_ODD, PARITY_EVEN.
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Legality-check functions for the parameters.
- Sub-module uart_rx_bit_voter:
  - Inputs: clk, rst, sample_trigger, synchronised line, tick index.
  - Outputs: vote, vote_valid (1-clk pulse at tick C+1).
- FSM, shift register, parity, handshake and overrun logic live in uart_rx_framed.

Test Plan:
- Defaults 8N1, OS=16; send 0xA5 with data_ready=1 → data=0xA5, data_valid 1 for 1 clk, all flags 0, 1 clk after the stop vote.
- DATA_BITS=7, PARITY_EVEN; send 0x53 with correct parity, then 0x53 with parity bit flipped → second word has parity_error=1; both words delivered.
- 8N1; send 0x3C with stop bit 0, line then held low 3 bit periods → data=0x3C, frame_error=1. No further word until the line returns high; a following 0x11 is received cleanly.
- Line held low for 12 bit periods → one word, data=0x00, frame_error=1, break_detected=1.
- Low glitch of 3 sample_trigger ticks in IDLE → no data_valid, state back in IDLE. A following 0x81 frame is received correctly.
- data_ready=0; send 0x12 then 0x34 back-to-back → data stays 0x12, overrun pulses once. Raise data_ready → 0x12 accepted, data_valid drops. Assert rst mid-third-frame → outputs go to reset values, no data_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and parameter checks for the framed UART receiver.
// The parity mode and state encodings are fixed-width so they can be compared directly.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic bit data_bits_ok(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit stop_bits_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit oversample_ok(input int n);
    return (n >= 4) && ((n % 2) == 0);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_voter.sv
// 3-sample majority vote around the bit centre; vote_valid pulses on the tick-(C+1) trigger.
// The third sample is the live line, so the vote is combinational in that cycle.
module uart_rx_bit_voter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int TW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_trigger,
  input  logic          line_sync,
  input  logic [TW-1:0] tick,
  output logic          vote,
  output logic          vote_valid
);

  localparam int C = OVERSAMPLE / 2;

  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (sample_trigger) begin
      if (tick == TW'(C - 1)) r_s0 <= line_sync;
      if (tick == TW'(C))     r_s1 <= line_sync;
    end
  end

  assign vote_valid = sample_trigger && (tick == TW'(C + 1));
  assign vote       = majority3(r_s0, r_s1, line_sync);

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver with parity/stop checking, mid-bit completion and a held-until-accepted output word.
// A frame that completes while an unaccepted word is pending is dropped with a 1-clk overrun pulse.
module uart_rx_framed #(
  parameter int                DATA_BITS  = 8,
  parameter uart_pkg::parity_e PARITY     = uart_pkg::PARITY_NONE,
  parameter int                STOP_BITS  = 1,
  parameter int                OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_trigger,
  input  logic                 raw_data,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 break_detected,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);

  localparam uart_pkg::rx_state_e S_IDLE  = uart_pkg::IDLE;
  localparam uart_pkg::rx_state_e S_START = uart_pkg::START;
  localparam uart_pkg::rx_state_e S_DATA  = uart_pkg::DATA;
  localparam uart_pkg::rx_state_e S_PAR   = uart_pkg::PARITY;
  localparam uart_pkg::rx_state_e S_STOP  = uart_pkg::STOP;
  localparam uart_pkg::rx_state_e S_WAIT  = uart_pkg::WAIT_IDLE;

  if (!(uart_pkg::data_bits_ok(DATA_BITS) && uart_pkg::stop_bits_ok(STOP_BITS) &&
        uart_pkg::oversample_ok(OVERSAMPLE))) begin : g_bad_params
    $error("uart_rx_framed: illegal DATA_BITS/STOP_BITS/OVERSAMPLE");
  end

  logic                r_sync1;
  logic                r_sync2;
  uart_pkg::rx_state_e r_state;
  logic [TW-1:0]       r_tick;
  logic [3:0]          r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                r_perr;
  logic                r_ferr;
  logic                r_all_zero;

  logic w_line;
  logic w_vote;
  logic w_vote_vld;
  logic w_active;
  logic w_final_stop;
  logic w_ferr_next;
  logic w_brk_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= raw_data;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line   = r_sync2;
  assign w_active = (r_state == S_START) || (r_state == S_DATA) ||
                    (r_state == S_PAR)   || (r_state == S_STOP);

  // Tick phase is pinned to 0 outside a frame so every frame starts aligned to its start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
    end else if (sample_trigger) begin
      if (!w_active || (r_tick == TW'(OVERSAMPLE - 1))) r_tick <= '0;
      else                                              r_tick <= r_tick + TW'(1);
    end
  end

  uart_rx_bit_voter #(
    .OVERSAMPLE (OVERSAMPLE),
    .TW         (TW)
  ) u_voter (
    .clk            (clk),
    .rst            (rst),
    .sample_trigger (sample_trigger),
    .line_sync      (w_line),
    .tick           (r_tick),
    .vote           (w_vote),
    .vote_valid     (w_vote_vld)
  );

  assign w_final_stop = (r_state == S_STOP) && w_vote_vld && (r_bit_cnt == 4'(STOP_BITS - 1));
  assign w_ferr_next  = r_ferr | ~w_vote;
  assign w_brk_next   = r_all_zero & ~w_vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_perr         <= 1'b0;
      r_ferr         <= 1'b0;
      r_all_zero     <= 1'b0;
      data           <= '0;
      data_valid     <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
      break_detected <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      if (w_final_stop) begin
        if (!data_valid || data_ready) begin
          data           <= r_shift;
          parity_error   <= r_perr;
          frame_error    <= w_ferr_next;
          break_detected <= w_brk_next;
          data_valid     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (sample_trigger && !w_line) begin
            r_state    <= S_START;
            r_bit_cnt  <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_all_zero <= 1'b1;
          end
        end
        S_START: begin
          if (w_vote_vld) r_state <= w_vote ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_vote_vld) begin
            r_shift    <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_all_zero <= r_all_zero & ~w_vote;
            if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY == uart_pkg::PARITY_NONE) ? S_STOP : S_PAR;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (w_vote_vld) begin
            r_perr     <= (PARITY == uart_pkg::PARITY_ODD) ? ~(^r_shift ^ w_vote)
                                                           :  (^r_shift ^ w_vote);
            r_all_zero <= r_all_zero & ~w_vote;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_vote_vld) begin
            r_ferr     <= w_ferr_next;
            r_all_zero <= w_brk_next;
            if (w_final_stop) r_state   <= w_ferr_next ? S_WAIT : S_IDLE;
            else              r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (sample_trigger && w_line) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench: an 8N1 receiver and a 7E1 receiver share clock and trigger (every other clk).
// Words are logged at the handshake and compared with hand-computed values.
module tb_uart_rx_framed;

  localparam int OS       = 16;
  localparam int BIT_CLKS = 2 * OS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sample_trigger;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       dv0, pe0, fe0, bk0, ov0;
  logic       dv1, pe1, fe1, bk1, ov1;

  uart_rx_framed #(
    .DATA_BITS (8), .PARITY (uart_pkg::PARITY_NONE), .STOP_BITS (1), .OVERSAMPLE (OS)
  ) dut0 (
    .clk (clk), .rst (rst), .sample_trigger (sample_trigger), .raw_data (rx0),
    .data (data0), .data_valid (dv0), .data_ready (rdy0), .parity_error (pe0),
    .frame_error (fe0), .break_detected (bk0), .overrun (ov0)
  );

  uart_rx_framed #(
    .DATA_BITS (7), .PARITY (uart_pkg::PARITY_EVEN), .STOP_BITS (1), .OVERSAMPLE (OS)
  ) dut1 (
    .clk (clk), .rst (rst), .sample_trigger (sample_trigger), .raw_data (rx1),
    .data (data1), .data_valid (dv1), .data_ready (rdy1), .parity_error (pe1),
    .frame_error (fe1), .break_detected (bk1), .overrun (ov1)
  );

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } word_t;

  word_t q0[$];
  word_t q1[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    ov0_cnt = 0;
  int    dv0_steps = 0;
  bit    ph = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clk per iteration; handshakes are logged just before the posedge that completes them.
  task automatic step(input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      if (dv0 && rdy0) begin
        w.d = {1'b0, data0}; w.pe = pe0; w.fe = fe0; w.bk = bk0; w.cyc = cyc;
        q0.push_back(w);
      end
      if (dv1 && rdy1) begin
        w.d = {2'b0, data1}; w.pe = pe1; w.fe = fe1; w.bk = bk1; w.cyc = cyc;
        q1.push_back(w);
      end
      @(negedge clk);
      cyc++;
      if (ov0) ov0_cnt++;
      if (dv0) dv0_steps++;
      ph = !ph;
      sample_trigger = ph;
    end
  endtask

  task automatic align();
    if (!sample_trigger) step(1);
  endtask

  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx0 = bits[i];
      else            rx1 = bits[i];
      step(BIT_CLKS);
    end
  endtask

  task automatic check_word(input string tag, input int which, input logic [8:0] d,
                            input logic pe, input logic fe, input logic bk);
    word_t w;
    int n;
    n = (which == 0) ? q0.size() : q1.size();
    check_eq({tag, "_avail"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      if (which == 0) w = q0.pop_front();
      else            w = q1.pop_front();
      check_eq({tag, "_data"}, 32'(w.d), 32'(d));
      check_eq({tag, "_perr"}, 32'(w.pe), 32'(pe));
      check_eq({tag, "_ferr"}, 32'(w.fe), 32'(fe));
      check_eq({tag, "_brk"},  32'(w.bk), 32'(bk));
    end
  endtask

  int t0;

  initial begin
    rst = 1'b1; sample_trigger = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    step(4);
    check_eq("rst_dv",   32'(dv0),   32'd0);
    check_eq("rst_data", 32'(data0), 32'd0);
    check_eq("rst_perr", 32'(pe0),   32'd0);
    check_eq("rst_ferr", 32'(fe0),   32'd0);
    check_eq("rst_brk",  32'(bk0),   32'd0);
    check_eq("rst_ovr",  32'(ov0),   32'd0);
    rst = 1'b0;
    step(40);

    // 8N1 0xA5: start fall to visible data_valid is 3 clks + 154 triggers * 2 clks = 311.
    dv0_steps = 0;
    align();
    t0 = cyc;
    send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
    step(64);
    check_eq("t1_count", q0.size(), 32'd1);
    if (q0.size() > 0) check_eq("t1_latency", 32'(q0[0].cyc - t0), 32'd311);
    check_word("t1", 0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    check_eq("t1_dv_clks", dv0_steps, 32'd1);

    // 7E1 0x53 has four ones: parity bit 0 is correct, 1 is wrong.
    align();
    send_bits(1, {1'b1, 1'b0, 7'h53, 1'b0}, 10);
    send_bits(1, {1'b1, 1'b1, 7'h53, 1'b0}, 10);
    step(64);
    check_eq("t2_count", q1.size(), 32'd2);
    check_word("t2a", 1, 9'h053, 1'b0, 1'b0, 1'b0);
    check_word("t2b", 1, 9'h053, 1'b1, 1'b0, 1'b0);

    // Bad stop bit then line held low: one flagged word, nothing more until the line rises.
    align();
    send_bits(0, {1'b0, 8'h3C, 1'b0}, 10);
    rx0 = 1'b0;
    step(3 * BIT_CLKS);
    check_eq("t3_held_low_count", q0.size(), 32'd1);
    rx0 = 1'b1;
    step(2 * BIT_CLKS);
    align();
    send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
    step(64);
    check_eq("t3_count", q0.size(), 32'd2);
    check_word("t3a", 0, 9'h03C, 1'b0, 1'b1, 1'b0);
    check_word("t3b", 0, 9'h011, 1'b0, 1'b0, 1'b0);

    // Break: 12 bit periods low.
    align();
    rx0 = 1'b0;
    step(12 * BIT_CLKS);
    rx0 = 1'b1;
    step(2 * BIT_CLKS);
    check_eq("t4_count", q0.size(), 32'd1);
    check_word("t4", 0, 9'h000, 1'b0, 1'b1, 1'b1);

    // 3-trigger glitch must not start a frame.
    align();
    rx0 = 1'b0;
    step(6);
    rx0 = 1'b1;
    step(2 * BIT_CLKS);
    check_eq("t5_glitch_count", q0.size(), 32'd0);
    align();
    send_bits(0, {1'b1, 8'h81, 1'b0}, 10);
    step(64);
    check_eq("t5_count", q0.size(), 32'd1);
    check_word("t5", 0, 9'h081, 1'b0, 1'b0, 1'b0);

    // Overrun: second frame dropped while the first is held.
    rdy0 = 1'b0;
    ov0_cnt = 0;
    align();
    send_bits(0, {1'b1, 8'h12, 1'b0}, 10);
    send_bits(0, {1'b1, 8'h34, 1'b0}, 10);
    step(16);
    check_eq("t6_held_data", 32'(data0), 32'h12);
    check_eq("t6_held_dv",   32'(dv0),   32'd1);
    check_eq("t6_ovr_pulses", ov0_cnt,   32'd1);
    rdy0 = 1'b1;
    step(1);
    check_eq("t6_dv_drop", 32'(dv0), 32'd0);
    check_eq("t6_count", q0.size(), 32'd1);
    check_word("t6", 0, 9'h012, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an 0xFF frame (line stays high afterwards).
    align();
    send_bits(0, {1'b1, 8'hFF, 1'b0}, 4);
    rst = 1'b1;
    step(1);
    check_eq("t7_rst_data", 32'(data0), 32'd0);
    check_eq("t7_rst_dv",   32'(dv0),   32'd0);
    check_eq("t7_rst_ovr",  32'(ov0),   32'd0);
    rst = 1'b0;
    rx0 = 1'b1;
    step(8 * BIT_CLKS);
    check_eq("t7_count", q0.size(), 32'd0);
    check_eq("t7_dv",    32'(dv0),  32'd0);
    check_eq("t7_ovr_total", ov0_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
